oam_dma: RTL and testbench
==========================

OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have parameter P_TRIGGER_ADDR, default 16'h4014: CPU write address that starts a DMA; the written byte is the source page.
REQ-002 SHALL have parameter P_TARGET_ADDR, default 16'h2004: fixed destination address (PPU OAMDATA).
REQ-003 SHALL have one clock; reset is asynchronous and active-low, with ports i_clk and i_reset_n.
REQ-004 i_clk  input  1  system clock, one CPU cycle per rising edge.
REQ-005 i_reset_n  input  1  asynchronous active-low reset.
REQ-006 i_cpu_rw  input  1  CPU read/write; 1 = read, 0 = write.
REQ-007 i_cpu_address  input  16  CPU address.
REQ-008 i_cpu_data  input  8  CPU write data.
REQ-009 i_data  input  8  read data returned from the system bus.
REQ-010 o_rw  output  1  system-bus read/write.
REQ-011 o_address  output  16  system-bus address.
REQ-012 o_data  output  8  system-bus write data.
REQ-013 o_rdy  output  1  CPU ready; 0 halts the CPU.
REQ-014 o_dma_active  output  1  1 while the DMA owns the system bus.

Function
REQ-015 States SHALL be IDLE, HALT, ALIGN, READ and WRITE.
REQ-016 Free-running parity flop r_odd SHALL toggle every clock.
  - Parity 0 = get cycle; parity 1 = put cycle.
REQ-017 Trigger: in IDLE, if a rising edge samples i_cpu_rw=0 and i_cpu_address=P_TRIGGER_ADDR, then:
  - i_cpu_data is latched as page;
  - the byte index is cleared to 0;
  - the next state is HALT.
REQ-018 o_rdy SHALL be 0 in every state except IDLE.
REQ-019 HALT SHALL last at least one cycle.
  - It exits only on a cycle where i_cpu_rw=1, because the CPU cannot halt on a write.
  - Exit goes to READ if the next cycle is a get cycle, otherwise to ALIGN.
REQ-020 ALIGN SHALL last exactly one cycle and then go to READ.
REQ-021 READ SHALL occur only on get cycles and drive:
  - o_rw=1;
  - o_address={page, index}.
  - i_data is latched at the end of the cycle.
  - The next state is WRITE.
REQ-022 WRITE SHALL drive:
  - o_rw=0;
  - o_address=P_TARGET_ADDR;
  - o_data=latched byte.
  - If index=8'hFF, the next state is IDLE.
  - Otherwise the index increments and the next state is READ.
REQ-023 o_dma_active SHALL be 1 in ALIGN, READ and WRITE, and 0 in IDLE and HALT.
REQ-024 When o_dma_active=0, o_address, o_rw and o_data SHALL pass through i_cpu_address, i_cpu_rw and i_cpu_data combinationally.
REQ-025 In ALIGN, the block SHALL drive o_rw=1 with o_address={page, 8'h00}; this dummy read has no side effects on the latch.
REQ-026 Total cycles with o_rdy=0 SHALL be 513 with no write stall, or 514 when an ALIGN cycle is needed.
  - Each write-cycle stall in HALT adds one cycle.
REQ-027 Index arithmetic is 8-bit; the source address never crosses out of page.
REQ-028 Writes to P_TRIGGER_ADDR while the state is not IDLE SHALL be ignored.

Reset
REQ-029 Assertion of i_reset_n=0 SHALL immediately, even mid-transfer, force:
  - state IDLE;
  - r_odd=0, index=0, page=0, latch=0;
  - o_rdy=1 and o_dma_active=0.
REQ-030 After reset, outputs SHALL equal pass-through of the CPU inputs.
REQ-031 A transfer aborted by reset SHALL NOT resume.

Structure
REQ-032 The state enum, P_TRIGGER_ADDR/P_TARGET_ADDR defaults and the cycle-count constants SHALL live in the shared CPU/bus package.
REQ-033 A separate sub-module is not warranted.
  - The 8-bit index counter, page register, data latch, parity flop and FSM are in one module.

Verification
REQ-034 Write 8'h02 to 16'h4014 with the trigger sampled on a put edge -> 513 cycles with o_rdy=0, starting with one HALT cycle. READ/WRITE pairs follow: 16'h0200 through 16'h02FF read, each byte written to 16'h2004 in the same order.
REQ-035 Same trigger, but the first cycle after HALT falls on a put cycle -> exactly one ALIGN cycle, 514 halted cycles, first READ on parity 0.
REQ-036 Memory preloaded with page 8'h03 = index XOR 8'hA5 -> the 256 WRITE cycles carry o_data 8'hA5, 8'hA4, ... 8'h5A, with no missing or duplicated bytes.
REQ-037 CPU issues two further write cycles after the trigger -> HALT holds; o_rdy stays 0 with o_dma_active=0 until i_cpu_rw=1.
REQ-038 Assert i_reset_n=0 at index 8'h40 during READ -> asynchronously o_rdy=1, o_dma_active=0, pass-through restored. After release, no further bus activity to 16'h2004 until a new trigger.
REQ-039 Write to 16'h4014 during an active DMA, plus a read of 16'h4014 while idle -> neither changes the page or starts a transfer.

Source files
------------

// File: rtl/oam_dma_pkg.sv
// Shared CPU/bus definitions for the OAM DMA engine: state encoding,
// default bus addresses and transfer cycle counts.
package oam_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_READ,
        ST_WRITE
    } dma_state_t;

    localparam logic [15:0] C_TRIGGER_ADDR = 16'h4014;
    localparam logic [15:0] C_TARGET_ADDR  = 16'h2004;

    localparam logic [7:0]  C_FIRST_INDEX  = 8'h00;
    localparam logic [7:0]  C_LAST_INDEX   = 8'hFF;

    // Halted-cycle totals for an unstalled transfer, with and without ALIGN.
    localparam int unsigned C_XFER_BYTES        = 256;
    localparam int unsigned C_HALT_CYCLES_MIN   = 2 * C_XFER_BYTES + 1;
    localparam int unsigned C_HALT_CYCLES_ALIGN = 2 * C_XFER_BYTES + 2;

    function automatic logic owns_bus(input dma_state_t s);
        return (s == ST_ALIGN) || (s == ST_READ) || (s == ST_WRITE);
    endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA engine: halts the CPU, copies one 256-byte page to a fixed
// destination register with alternating get/put cycles.
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter logic [15:0] P_TRIGGER_ADDR = C_TRIGGER_ADDR,
    parameter logic [15:0] P_TARGET_ADDR  = C_TARGET_ADDR
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_cpu_rw,
    input  logic [15:0] i_cpu_address,
    input  logic [7:0]  i_cpu_data,
    input  logic [7:0]  i_data,
    output logic        o_rw,
    output logic [15:0] o_address,
    output logic [7:0]  o_data,
    output logic        o_rdy,
    output logic        o_dma_active
);

    // state    | meaning
    // ST_IDLE  | CPU owns the bus, watching for a trigger write
    // ST_HALT  | CPU halted, waiting for it to reach a read cycle
    // ST_ALIGN | dummy read to line the first READ up with a get cycle
    // ST_READ  | fetch byte {page, index} (get cycle)
    // ST_WRITE | store latched byte to the target register (put cycle)

    dma_state_t state, state_nxt;
    logic       r_odd;
    logic [7:0] page;
    logic [7:0] index;
    logic [7:0] latch;
    logic       trigger;

    assign trigger = (state == ST_IDLE) && !i_cpu_rw && (i_cpu_address == P_TRIGGER_ADDR);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= ST_IDLE;
            r_odd <= 1'b0;
            page  <= 8'h00;
            index <= C_FIRST_INDEX;
            latch <= 8'h00;
        end else begin
            state <= state_nxt;
            r_odd <= ~r_odd;
            if (trigger) begin
                page  <= i_cpu_data;
                index <= C_FIRST_INDEX;
            end
            if (state == ST_READ) begin
                latch <= i_data;
            end
            if ((state == ST_WRITE) && (index != C_LAST_INDEX)) begin
                index <= index + 8'h01;
            end
        end
    end

    // HALT looks ahead: the cycle after this one is a get cycle when r_odd is 1 now.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (trigger) state_nxt = ST_HALT;
            ST_HALT:  if (i_cpu_rw) state_nxt = r_odd ? ST_READ : ST_ALIGN;
            ST_ALIGN: state_nxt = ST_READ;
            ST_READ:  state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = (index == C_LAST_INDEX) ? ST_IDLE : ST_READ;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_rw         = i_cpu_rw;
        o_address    = i_cpu_address;
        o_data       = i_cpu_data;
        o_rdy        = (state == ST_IDLE);
        o_dma_active = owns_bus(state);
        case (state)
            ST_ALIGN: begin
                o_rw      = 1'b1;
                o_address = {page, C_FIRST_INDEX};
                o_data    = latch;
            end
            ST_READ: begin
                o_rw      = 1'b1;
                o_address = {page, index};
                o_data    = latch;
            end
            ST_WRITE: begin
                o_rw      = 1'b0;
                o_address = P_TARGET_ADDR;
                o_data    = latch;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Scoreboard bench for oam_dma: expected target writes are queued at trigger
// time and popped as the DUT issues them.
module tb_oam_dma;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_cpu_rw = 1'b1;
    logic [15:0] i_cpu_address = 16'h8000;
    logic [7:0]  i_cpu_data = 8'h3C;
    logic [7:0]  i_data;
    logic        o_rw;
    logic [15:0] o_address;
    logic [7:0]  o_data;
    logic        o_rdy;
    logic        o_dma_active;

    oam_dma dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_cpu_rw      (i_cpu_rw),
        .i_cpu_address (i_cpu_address),
        .i_cpu_data    (i_cpu_data),
        .i_data        (i_data),
        .o_rw          (o_rw),
        .o_address     (o_address),
        .o_data        (o_data),
        .o_rdy         (o_rdy),
        .o_dma_active  (o_dma_active)
    );

    always #5 i_clk = ~i_clk;

    logic [7:0]  mem [0:65535];
    logic [23:0] wr_q [$];
    logic [23:0] wr_exp;
    int          vectors = 0;
    int          miscompares = 0;
    int          low_cnt = 0;
    logic        tb_odd;

    always_comb i_data = mem[o_address];

    // Reference parity: 0 = get cycle, 1 = put cycle.
    always @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) tb_odd <= 1'b0;
        else            tb_odd <= ~tb_odd;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge i_clk) begin
        if (i_reset_n) begin
            if (!o_rdy) low_cnt++;
            if (o_dma_active && !o_rw) begin
                if (wr_q.size() == 0) begin
                    check_val("extra_wr", 32'(o_address), 32'hFFFF_FFFF);
                end else begin
                    wr_exp = wr_q.pop_front();
                    check_val("wr_addr", 32'(o_address), 32'(wr_exp[23:8]));
                    check_val("wr_data", 32'(o_data), 32'(wr_exp[7:0]));
                end
            end
            if (!o_dma_active && !o_rw && (o_address == 16'h2004)) begin
                check_val("stray_wr", 32'(o_address), 32'h0);
            end
        end
    end

    task automatic do_dma(input logic [7:0] page, input int n_stall, input bit want_align,
                          input bit busy_trig);
        logic p_t;
        bit   done;
        int   expect_low;
        p_t = want_align ^ n_stall[0];
        i_cpu_rw = 1'b1;
        i_cpu_address = 16'h8000;
        @(posedge i_clk); #1;
        while (tb_odd != p_t) begin
            @(posedge i_clk); #1;
        end
        for (int i = 0; i < 256; i++) wr_q.push_back({16'h2004, mem[{page, i[7:0]}]});
        low_cnt = 0;
        i_cpu_rw = 1'b0;
        i_cpu_address = 16'h4014;
        i_cpu_data = page;
        @(posedge i_clk); #1;
        for (int k = 0; k <= n_stall; k++) begin
            i_cpu_rw = (k < n_stall) ? 1'b0 : 1'b1;
            i_cpu_address = 16'(16'h0300 + k);
            i_cpu_data = 8'(8'hC0 + k);
            @(negedge i_clk);
            check_val("halt_rdy", 32'(o_rdy), 32'h0);
            check_val("halt_active", 32'(o_dma_active), 32'h0);
            check_val("halt_pass_addr", 32'(o_address), 32'(i_cpu_address));
            @(posedge i_clk); #1;
        end
        i_cpu_address = 16'h8000;
        if (want_align) begin
            @(negedge i_clk);
            check_val("align_active", 32'(o_dma_active), 32'h1);
            check_val("align_rw", 32'(o_rw), 32'h1);
            check_val("align_addr", 32'(o_address), 32'({page, 8'h00}));
            @(posedge i_clk); #1;
        end
        @(negedge i_clk);
        check_val("first_rd_parity", 32'(tb_odd), 32'h0);
        check_val("first_rd_rw", 32'(o_rw), 32'h1);
        check_val("first_rd_addr", 32'(o_address), 32'({page, 8'h00}));
        if (busy_trig) begin
            i_cpu_rw = 1'b0;
            i_cpu_address = 16'h4014;
            i_cpu_data = 8'h77;
        end
        done = 1'b0;
        for (int cyc = 0; cyc < 600 && !done; cyc++) begin
            @(posedge i_clk); #1;
            if (o_rdy) done = 1'b1;
        end
        i_cpu_rw = 1'b1;
        i_cpu_address = 16'h8000;
        check_val("dma_done", 32'(done), 32'h1);
        expect_low = 513 + n_stall + int'(want_align);
        check_val("rdy_low_cycles", 32'(low_cnt), 32'(expect_low));
        check_val("wr_q_empty", 32'(wr_q.size()), 32'h0);
        wr_q.delete();
    endtask

    initial begin
        bit found;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[{8'h03, i[7:0]}] = i[7:0] ^ 8'hA5;

        #12;
        check_val("rst_rdy", 32'(o_rdy), 32'h1);
        check_val("rst_active", 32'(o_dma_active), 32'h0);
        check_val("rst_pass_addr", 32'(o_address), 32'h8000);
        check_val("rst_pass_rw", 32'(o_rw), 32'h1);
        check_val("rst_pass_data", 32'(o_data), 32'h3C);
        @(posedge i_clk); #2;
        i_reset_n = 1'b1;

        do_dma(8'h02, 0, 1'b0, 1'b0);
        do_dma(8'h02, 0, 1'b1, 1'b0);
        do_dma(8'h03, 2, 1'b0, 1'b0);
        do_dma(8'h04, 1, 1'b1, 1'b1);

        i_cpu_rw = 1'b1;
        i_cpu_address = 16'h4014;
        i_cpu_data = 8'h99;
        repeat (4) begin
            @(negedge i_clk);
            check_val("idle_rd_rdy", 32'(o_rdy), 32'h1);
            check_val("idle_rd_active", 32'(o_dma_active), 32'h0);
        end
        do_dma(8'h06, 0, 1'b0, 1'b0);

        // Abort a transfer while it reads index 8'h40.
        @(posedge i_clk); #1;
        for (int i = 0; i < 256; i++) wr_q.push_back({16'h2004, mem[{8'h05, i[7:0]}]});
        i_cpu_rw = 1'b0;
        i_cpu_address = 16'h4014;
        i_cpu_data = 8'h05;
        @(posedge i_clk); #1;
        i_cpu_rw = 1'b1;
        i_cpu_address = 16'h8000;
        found = 1'b0;
        for (int cyc = 0; cyc < 600 && !found; cyc++) begin
            @(negedge i_clk);
            if (o_dma_active && o_rw && (o_address == 16'h0540)) found = 1'b1;
        end
        check_val("abort_point_seen", 32'(found), 32'h1);
        #2;
        check_val("pre_reset_writes", 32'(wr_q.size()), 32'd192);
        i_cpu_rw = 1'b0;
        i_cpu_address = 16'h1234;
        i_cpu_data = 8'h5A;
        i_reset_n = 1'b0;
        #1;
        check_val("abort_rdy", 32'(o_rdy), 32'h1);
        check_val("abort_active", 32'(o_dma_active), 32'h0);
        check_val("abort_pass_addr", 32'(o_address), 32'h1234);
        check_val("abort_pass_rw", 32'(o_rw), 32'h0);
        check_val("abort_pass_data", 32'(o_data), 32'h5A);
        wr_q.delete();
        i_cpu_rw = 1'b1;
        i_cpu_address = 16'h8000;
        @(posedge i_clk); #2;
        i_reset_n = 1'b1;
        low_cnt = 0;
        repeat (600) @(posedge i_clk);
        @(negedge i_clk);
        check_val("no_resume_rdy_low", 32'(low_cnt), 32'h0);
        check_val("no_resume_rdy", 32'(o_rdy), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
